mu0_mem_arbiter: RTL and testbench
==================================

# mu0_mem_arbiter

Two-port arbiter and access sequencer that shares the MU0 single-port memory between the CPU control/datapath (port 0) and a debug/loader requester (port 1). It accepts independent request/acknowledge handshakes, selects one access at a time, drives the memory through a registered request phase, waits for memory ready, returns read data, and aborts hung accesses with a timeout. It sits between the CPU core, the debug port and the memory model.

## Interface
- `ADDR_W`, default 12: address width (MU0 12-bit operand field).
- `DATA_W`, default 16: data word width.
- `TIMEOUT`, default 15: maximum cycles in ACCESS before abort (≥1).
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `p0_req`, `p1_req`  in  1: access request; held until `pN_ack`.
- `p0_rnw`, `p1_rnw`  in  1: 1 = read, 0 = write.
- `p0_addr`, `p1_addr`  in  ADDR_W: access address.
- `p0_wdata`, `p1_wdata`  in  DATA_W: write data.
- `p1_lock`  in  1: debug port bus lock; while high, port 0 is never granted.
- `p0_ack`, `p1_ack`  out  1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  DATA_W: read data, valid with ack, held until the next ack to that port.
- `p0_err`, `p1_err`  out  1: asserted with ack when the access timed out.
- `mem_rq`  out  1: memory request (registered).
- `mem_rnw`  out  1: memory direction (registered).
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W: registered access fields.
- `mem_rdata`  in  DATA_W; `mem_rdy`  in  1: memory completion, sampled only in ACCESS.
- `busy`  out  1: high in GRANT and ACCESS.

## Operation
- States: IDLE, GRANT, ACCESS, DONE.
- IDLE: eligible = `p0_req & ~p1_lock`, `p1_req`. No eligible request → stay. One eligible → select it. Both eligible → round-robin: the port not granted last wins. Selection latches the port id, rnw, addr and wdata → GRANT.
- GRANT: drive `mem_rq`=1 with the latched fields → ACCESS. Timeout counter cleared.
- ACCESS: `mem_rq` held high, fields stable. `mem_rdy`=1 → capture `mem_rdata` for reads → DONE. Otherwise the counter increments; when the counter reaches TIMEOUT without `mem_rdy` → DONE with error flag set.
- DONE: `mem_rq`=0; pulse ack of the owning port, err=flag, rdata updated only for successful reads (a timed-out read leaves rdata unchanged); last-grant pointer = owner → IDLE.
- Writes never update rdata. Requests deasserted before ack are ignored once latched; the access completes and is still acked.
- `p1_lock` affects selection only in IDLE; an in-flight port 0 access completes normally.
- Timeout counter is $clog2(TIMEOUT+1) bits and saturates; there is no wrap.

## Timing
- Reset (asynchronous, any state): state IDLE; all acks, errs, `mem_rq`, `busy` = 0; `mem_rnw`=1; `mem_addr`, `mem_wdata`, both rdata = 0; last-grant = port 1, so port 0 wins the first contention. Reset mid-ACCESS drops `mem_rq` immediately and issues no ack.
- Request sampled at edge n (IDLE) → `mem_rq` high from edge n+1 → `mem_rdy` seen at edge m → ack high during cycle m+1 → IDLE at m+2.
- Zero-wait memory (`mem_rdy` high in first ACCESS cycle): request to ack = 3 cycles; back-to-back throughput is one access per 4 cycles.
- A requester holding req high through ack is re-arbitrated in the next IDLE cycle as a new request.
- Timeout: ack+err 1 cycle after TIMEOUT ACCESS cycles.

## Structure
- Shared package `mu0_pkg`: state enum (IDLE/GRANT/ACCESS/DONE), default ADDR_W/DATA_W, port-id constants PORT_CPU=0, PORT_DBG=1.
- One sub-module is natural: `rr_pick2`, a combinational two-way round-robin selector (eligible[1:0], last → winner, valid). The rest is a single FSM plus datapath registers.

## Test plan
- Single read, port 0, addr 0x005, memory returns 0xBEEF with 2 wait cycles → `p0_ack` one cycle, `p0_rdata`=0xBEEF, `p0_err`=0, `p1_ack` never.
- Both ports request together repeatedly (p0 read 0x010, p1 write 0x020/0x1234) → grants alternate P0, P1, P0, P1; the memory sees the write with `mem_rnw`=0 and wdata 0x1234.
- `p1_lock`=1 with both requesting for 4 accesses → only port 1 is served; release the lock → port 0 is served next.
- `mem_rdy` held low, TIMEOUT=15 → `mem_rq` high exactly 15 cycles, then ack+err to the owner, rdata unchanged, FSM returns to IDLE.
- Assert `rst` mid-ACCESS → outputs reach reset values asynchronously, no ack; after release a pending p1 request is served normally.
- Zero-wait memory, p0 holds req high continuously → ack every 4 cycles, addresses latched on each IDLE visit.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: arbiter state encoding, default bus widths and port ids.
package mu0_pkg;

    localparam int MU0_ADDR_W = 12;
    localparam int MU0_DATA_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mu0_mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the port not granted last wins.
module rr_pick2
    import mu0_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       valid_o
);

    // Winner selection from the eligibility vector and last-grant pointer.
    always_comb begin
        winner_o = PORT_CPU;
        valid_o  = 1'b0;
        case (eligible_i)
            2'b01: begin
                winner_o = PORT_CPU;
                valid_o  = 1'b1;
            end
            2'b10: begin
                winner_o = PORT_DBG;
                valid_o  = 1'b1;
            end
            2'b11: begin
                winner_o = ~last_i;
                valid_o  = 1'b1;
            end
            default: begin
                winner_o = PORT_CPU;
                valid_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Shares the MU0 single-port memory between the CPU (port 0) and the debug/loader port (port 1).
module mu0_mem_arbiter
    import mu0_pkg::*;
#(
    parameter int ADDR_W  = MU0_ADDR_W,
    parameter int DATA_W  = MU0_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_rnw_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    input  logic              p1_req_i,
    input  logic              p1_rnw_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    input  logic              p1_lock_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    output logic              p0_err_o,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              p1_err_o,
    output logic              mem_rq_o,
    output logic              mem_rnw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rdy_i,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_rq_q, mem_rq_d;
    logic              mem_rnw_q, mem_rnw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
    logic              p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic              busy_q, busy_d;

    logic [1:0]        elig;
    logic              pick_port;
    logic              pick_valid;

    // The lock masks only the CPU request, and only matters at selection time.
    assign elig = {p1_req_i, p0_req_i & ~p1_lock_i};

    rr_pick2 u_pick (
        .eligible_i (elig),
        .last_i     (last_q),
        .winner_o   (pick_port),
        .valid_o    (pick_valid)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_rq_d    = mem_rq_q;
        mem_rnw_d   = mem_rnw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        busy_d      = busy_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_err_d    = 1'b0;
        p1_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_port;
                    if (pick_port == PORT_DBG) begin
                        mem_rnw_d   = p1_rnw_i;
                        mem_addr_d  = p1_addr_i;
                        mem_wdata_d = p1_wdata_i;
                    end else begin
                        mem_rnw_d   = p0_rnw_i;
                        mem_addr_d  = p0_addr_i;
                        mem_wdata_d = p0_wdata_i;
                    end
                    busy_d  = 1'b1;
                    state_d = GRANT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                mem_rq_d = 1'b1;
                cnt_d    = {CNT_W{1'b0}};
                busy_d   = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (mem_rdy_i || (cnt_q >= CNT_LAST)) begin
                    // Completion and timeout share the exit; only a successful read loads rdata.
                    mem_rq_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                    if (owner_q == PORT_DBG) begin
                        p1_ack_d = 1'b1;
                        p1_err_d = ~mem_rdy_i;
                        if (mem_rdy_i && mem_rnw_q) begin
                            p1_rdata_d = mem_rdata_i;
                        end else begin
                            p1_rdata_d = p1_rdata_q;
                        end
                    end else begin
                        p0_ack_d = 1'b1;
                        p0_err_d = ~mem_rdy_i;
                        if (mem_rdy_i && mem_rnw_q) begin
                            p0_rdata_d = mem_rdata_i;
                        end else begin
                            p0_rdata_d = p0_rdata_q;
                        end
                    end
                end else begin
                    busy_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            DONE: begin
                last_d  = owner_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                mem_rq_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves last-grant on port 1 so port 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= PORT_CPU;
            last_q      <= PORT_DBG;
            cnt_q       <= {CNT_W{1'b0}};
            mem_rq_q    <= 1'b0;
            mem_rnw_q   <= 1'b1;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= {DATA_W{1'b0}};
            p1_rdata_q  <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_rq_q    <= mem_rq_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign p0_ack_o    = p0_ack_q;
    assign p1_ack_o    = p1_ack_q;
    assign p0_err_o    = p0_err_q;
    assign p1_err_o    = p1_err_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;
    assign mem_rq_o    = mem_rq_q;
    assign mem_rnw_o   = mem_rnw_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Directed self-checking bench for mu0_mem_arbiter with a behavioural wait-state memory.
module tb_mu0_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_rnw, p1_req, p1_rnw, p1_lock;
    logic [11:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_rq, mem_rnw, mem_rdy, busy;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem_arr [0:4095];
    int          mem_wait;
    logic        rdy_stuck;
    int          wcnt;
    int          wr_count;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    int n_checks;
    int n_fail;

    mu0_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p0_req_i    (p0_req),
        .p0_rnw_i    (p0_rnw),
        .p0_addr_i   (p0_addr),
        .p0_wdata_i  (p0_wdata),
        .p1_req_i    (p1_req),
        .p1_rnw_i    (p1_rnw),
        .p1_addr_i   (p1_addr),
        .p1_wdata_i  (p1_wdata),
        .p1_lock_i   (p1_lock),
        .p0_ack_o    (p0_ack),
        .p0_rdata_o  (p0_rdata),
        .p0_err_o    (p0_err),
        .p1_ack_o    (p1_ack),
        .p1_rdata_o  (p1_rdata),
        .p1_err_o    (p1_err),
        .mem_rq_o    (mem_rq),
        .mem_rnw_o   (mem_rnw),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_rdy_i   (mem_rdy),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: answers mem_wait cycles after seeing mem_rq, unless stuck.
    initial begin
        mem_rdy   = 1'b0;
        mem_rdata = 16'h0000;
        wcnt      = 0;
        wr_count  = 0;
        wr_addr   = 12'h000;
        wr_data   = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_rq && !rdy_stuck) begin
                if (wcnt == mem_wait) begin
                    mem_rdy   = 1'b1;
                    mem_rdata = mem_arr[mem_addr];
                    if (!mem_rnw) begin
                        mem_arr[mem_addr] = mem_wdata;
                        wr_count++;
                        wr_addr = mem_addr;
                        wr_data = mem_wdata;
                    end
                end else begin
                    mem_rdy = 1'b0;
                end
                wcnt++;
            end else begin
                mem_rdy = 1'b0;
                wcnt    = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_until_ack(input int limit, output int port, output int cycles,
                                 output int rq_cycles, output logic err,
                                 output logic [15:0] rdata, output logic found);
        found = 1'b0; port = -1; cycles = 0; rq_cycles = 0; err = 1'b0; rdata = 16'h0000;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            cycles++;
            if (mem_rq) rq_cycles++;
            if (p0_ack || p1_ack) begin
                found = 1'b1;
                port  = p1_ack ? 1 : 0;
                err   = p1_ack ? p1_err : p0_err;
                rdata = p1_ack ? p1_rdata : p0_rdata;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({p0_ack, p1_ack, p0_err, p1_err, mem_rq, busy, mem_rnw} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000001", {p0_ack, p1_ack, p0_err, p1_err, mem_rq, busy, mem_rnw});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== 60'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, p0_rdata, p1_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int port, cyc, rqc; logic err, found; logic [15:0] rd;
        mem_wait = 2;
        p0_rnw = 1'b1; p0_addr = 12'h005; p0_req = 1'b1;
        run_until_ack(30, port, cyc, rqc, err, rd, found);
        p0_req = 1'b0;
        n_checks++;
        if (!found || port != 0) begin
            n_fail++;
            $display("FAIL single_read_port: got found=%0b port=%0d expected found=1 port=0", found, port);
        end
        n_checks++;
        if (cyc != 5 || rqc != 3) begin
            n_fail++;
            $display("FAIL single_read_timing: got cycles=%0d rq=%0d expected cycles=5 rq=3", cyc, rqc);
        end
        n_checks++;
        if (rd !== 16'hBEEF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_data: got rdata=%h err=%b expected BEEF 0", rd, err);
        end
        @(negedge clk);
        n_checks++;
        if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || p0_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL single_read_pulse: got ack0=%b ack1=%b rdata=%h expected 0 0 BEEF", p0_ack, p1_ack, p0_rdata);
        end
    endtask

    task automatic test_round_robin();
        int port, cyc, rqc; logic err, found; logic [15:0] rd;
        int exp_port [4];
        int wr_before;
        exp_port = '{0, 1, 0, 1};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mem_wait = 0;
        p0_rnw = 1'b1; p0_addr = 12'h010;
        p1_rnw = 1'b0; p1_addr = 12'h020; p1_wdata = 16'h1234;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_before = wr_count;
            run_until_ack(30, port, cyc, rqc, err, rd, found);
            n_checks++;
            if (!found || port != exp_port[k]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got port=%0d expected %0d", k, port, exp_port[k]);
            end
            n_checks++;
            if (exp_port[k] == 0) begin
                if (rd !== 16'h0A5A || wr_count != wr_before) begin
                    n_fail++;
                    $display("FAIL rr_p0_read[%0d]: got rdata=%h writes=%0d expected 0A5A %0d", k, rd, wr_count - wr_before, 0);
                end
            end else begin
                if (wr_count != wr_before + 1 || wr_addr !== 12'h020 || wr_data !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL rr_p1_write[%0d]: got writes=%0d addr=%h data=%h expected 1 020 1234", k, wr_count - wr_before, wr_addr, wr_data);
                end
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        n_checks++;
        if (p1_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL rr_write_rdata: got %h expected 0000", p1_rdata);
        end
    endtask

    task automatic test_lock();
        int port, cyc, rqc; logic err, found; logic [15:0] rd;
        repeat (2) @(negedge clk);
        p1_lock = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_until_ack(30, port, cyc, rqc, err, rd, found);
            n_checks++;
            if (!found || port != 1) begin
                n_fail++;
                $display("FAIL lock_grant[%0d]: got port=%0d expected 1", k, port);
            end
        end
        p1_lock = 1'b0;
        run_until_ack(30, port, cyc, rqc, err, rd, found);
        p0_req = 1'b0; p1_req = 1'b0;
        n_checks++;
        if (!found || port != 0 || rd !== 16'h0A5A) begin
            n_fail++;
            $display("FAIL lock_release: got port=%0d rdata=%h expected 0 0A5A", port, rd);
        end
    endtask

    task automatic test_timeout();
        int port, cyc, rqc; logic err, found; logic [15:0] rd;
        repeat (2) @(negedge clk);
        rdy_stuck = 1'b1;
        p0_rnw = 1'b1; p0_addr = 12'h033; p0_req = 1'b1;
        run_until_ack(40, port, cyc, rqc, err, rd, found);
        p0_req = 1'b0;
        n_checks++;
        if (!found || port != 0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ack: got found=%0b port=%0d err=%b expected 1 0 1", found, port, err);
        end
        n_checks++;
        if (rqc != 15 || cyc != 17) begin
            n_fail++;
            $display("FAIL timeout_len: got rq=%0d cycles=%0d expected 15 17", rqc, cyc);
        end
        n_checks++;
        if (rd !== 16'h0A5A) begin
            n_fail++;
            $display("FAIL timeout_rdata: got %h expected 0A5A", rd);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_rq !== 1'b0 || p0_ack !== 1'b0 || p0_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: got busy=%b rq=%b ack=%b err=%b expected 0 0 0 0", busy, mem_rq, p0_ack, p0_err);
        end
        rdy_stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int port, cyc, rqc; logic err, found; logic [15:0] rd;
        repeat (2) @(negedge clk);
        rdy_stuck = 1'b1;
        p0_rnw = 1'b1; p0_addr = 12'h005; p0_req = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (mem_rq !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_access: got rq=%b busy=%b expected 1 1", mem_rq, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (mem_rq !== 1'b0 || busy !== 1'b0 || mem_rnw !== 1'b1 || mem_addr !== 12'h000 || p0_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_async: got rq=%b busy=%b rnw=%b addr=%h rdata=%h expected 0 0 1 000 0000", mem_rq, busy, mem_rnw, mem_addr, p0_rdata);
        end
        p0_req = 1'b0;
        p1_rnw = 1'b1; p1_addr = 12'h044; p1_req = 1'b1;
        rdy_stuck = 1'b0; mem_wait = 1;
        @(negedge clk);
        n_checks++;
        if (p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_noack: got ack0=%b ack1=%b expected 0 0", p0_ack, p1_ack);
        end
        rst = 1'b0;
        run_until_ack(30, port, cyc, rqc, err, rd, found);
        p1_req = 1'b0;
        n_checks++;
        if (!found || port != 1 || cyc != 4 || rd !== 16'h4444 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_p1: got port=%0d cycles=%0d rdata=%h err=%b expected 1 4 4444 0", port, cyc, rd, err);
        end
    endtask

    task automatic test_back_to_back();
        int port, cyc, rqc; logic err, found; logic [15:0] rd;
        repeat (2) @(negedge clk);
        mem_wait = 0;
        p0_rnw = 1'b1; p0_addr = 12'h100; p0_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_until_ack(30, port, cyc, rqc, err, rd, found);
            p0_addr = 12'h100 + 12'(k + 1);
            n_checks++;
            if (!found || port != 0 || cyc != ((k == 0) ? 3 : 4)) begin
                n_fail++;
                $display("FAIL b2b_timing[%0d]: got port=%0d cycles=%0d expected 0 %0d", k, port, cyc, (k == 0) ? 3 : 4);
            end
            n_checks++;
            if (rd !== (16'h1100 + 16'(k))) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", k, rd, 16'h1100 + 16'(k));
            end
        end
        p0_req = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        p0_req = 1'b0; p0_rnw = 1'b1; p0_addr = 12'h000; p0_wdata = 16'h0000;
        p1_req = 1'b0; p1_rnw = 1'b1; p1_addr = 12'h000; p1_wdata = 16'h0000;
        p1_lock = 1'b0; mem_wait = 0; rdy_stuck = 1'b0;
        for (int a = 0; a < 4096; a++) mem_arr[a] = 16'h0000;
        mem_arr[12'h005] = 16'hBEEF;
        mem_arr[12'h010] = 16'h0A5A;
        mem_arr[12'h033] = 16'h3333;
        mem_arr[12'h044] = 16'h4444;
        mem_arr[12'h100] = 16'h1100;
        mem_arr[12'h101] = 16'h1101;
        mem_arr[12'h102] = 16'h1102;

        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
